// File: rtl/prefetch_dma_arbiter.sv
// rtl/prefetch_dma_arbiter.sv - demand/prefetch arbiter sharing one cache DMA request port
module prefetch_dma_arbiter #(
  parameter int addr_width_p         = 32,
  parameter int block_offset_width_p = 6,
  parameter int pf_queue_els_p       = 4,
  parameter int drop_count_width_p   = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              pf_enable_i,
  input  logic                              demand_v_i,
  input  logic [addr_width_p-1:0]           demand_addr_i,
  output logic                              demand_ready_o,
  output logic                              demand_done_o,
  input  logic                              pf_v_i,
  input  logic [addr_width_p-1:0]           pf_addr_i,
  output logic                              dma_pkt_v_o,
  output logic [addr_width_p-1:0]           dma_pkt_addr_o,
  output logic                              dma_pkt_is_pf_o,
  input  logic                              dma_pkt_ready_i,
  input  logic                              dma_done_i,
  output logic                              pf_fill_done_o,
  output logic [addr_width_p-1:0]           pf_fill_addr_o,
  output logic [$clog2(pf_queue_els_p):0]   pf_occupancy_o,
  output logic [drop_count_width_p-1:0]     pf_drop_count_o
);

  localparam int PW = $clog2(pf_queue_els_p);
  localparam int BW = addr_width_p - block_offset_width_p;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(pf_queue_els_p);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [BW-1:0]                 r_blk;
  logic                          r_is_pf;
  logic [BW-1:0]                 r_q_blk [pf_queue_els_p];
  logic                          r_q_val [pf_queue_els_p];
  logic [PW-1:0]                 r_head;
  logic [PW-1:0]                 r_tail;
  logic [PW:0]                   r_count;
  logic [drop_count_width_p-1:0] r_drops;

  logic [BW-1:0] w_dem_blk;
  logic [BW-1:0] w_pf_blk;
  logic          w_dem_acc;
  logic          w_pop;
  logic          w_pop_issue;
  logic          w_push_req;
  logic          w_q_hit;
  logic          w_busy_hit;
  logic          w_dem_hit;
  logic          w_full;
  logic          w_drop;
  logic          w_push;
  logic          w_unused;

  assign w_dem_blk = demand_addr_i[addr_width_p-1:block_offset_width_p];
  assign w_pf_blk  = pf_addr_i[addr_width_p-1:block_offset_width_p];
  assign w_unused  = ^{demand_addr_i[block_offset_width_p-1:0], pf_addr_i[block_offset_width_p-1:0]};

  // Next-state and handshake outputs; demand always beats a queued prefetch in IDLE
  always_comb begin
    w_state_nxt    = r_state;
    w_dem_acc      = 1'b0;
    w_pop          = 1'b0;
    w_pop_issue    = 1'b0;
    demand_ready_o = 1'b0;
    dma_pkt_v_o    = 1'b0;
    demand_done_o  = 1'b0;
    pf_fill_done_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        demand_ready_o = 1'b1;
        if (demand_v_i) begin
          w_dem_acc   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (pf_enable_i && (r_count != '0)) begin
          // Squashed heads are popped and discarded without leaving IDLE
          w_pop = 1'b1;
          if (r_q_val[r_head]) begin
            w_pop_issue = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        dma_pkt_v_o = 1'b1;
        if (dma_pkt_ready_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (dma_done_i) begin
          w_state_nxt    = ST_IDLE;
          demand_done_o  = ~r_is_pf;
          pf_fill_done_o = r_is_pf;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Push filtering against start-of-cycle queue, in-flight block and same-cycle demand
  always_comb begin
    w_q_hit = 1'b0;
    for (int i = 0; i < pf_queue_els_p; i++) begin
      if (r_q_val[i] && (r_q_blk[i] == w_pf_blk)) w_q_hit = 1'b1;
    end
  end

  assign w_push_req = pf_v_i & pf_enable_i;
  assign w_full     = (r_count == FULL_COUNT);
  assign w_busy_hit = (r_state != ST_IDLE) && (r_blk == w_pf_blk);
  assign w_dem_hit  = w_dem_acc && (w_dem_blk == w_pf_blk);
  assign w_drop     = w_push_req & (w_full | w_q_hit | w_busy_hit | w_dem_hit);
  assign w_push     = w_push_req & ~w_drop;

  // State register and latched transaction block/source
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_blk   <= '0;
      r_is_pf <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dem_acc) begin
        r_blk   <= w_dem_blk;
        r_is_pf <= 1'b0;
      end else if (w_pop_issue) begin
        r_blk   <= r_q_blk[r_head];
        r_is_pf <= 1'b1;
      end
    end
  end

  // Prefetch queue: flush when disabled, otherwise squash, pop and push
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < pf_queue_els_p; i++) begin
        r_q_blk[i] <= '0;
        r_q_val[i] <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (!pf_enable_i) begin
      for (int i = 0; i < pf_queue_els_p; i++) r_q_val[i] <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < pf_queue_els_p; i++) begin
        if (w_dem_acc && r_q_val[i] && (r_q_blk[i] == w_dem_blk)) r_q_val[i] <= 1'b0;
      end
      if (w_pop) begin
        r_q_val[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_q_blk[r_tail] <= w_pf_blk;
        r_q_val[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating drop counter; survives prefetch disable
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_drops <= '0;
    end else if (w_drop && (r_drops != '1)) begin
      r_drops <= r_drops + 1'b1;
    end
  end

  assign dma_pkt_addr_o  = {r_blk, {block_offset_width_p{1'b0}}};
  assign dma_pkt_is_pf_o = r_is_pf;
  assign pf_fill_addr_o  = {r_blk, {block_offset_width_p{1'b0}}};
  assign pf_occupancy_o  = r_count;
  assign pf_drop_count_o = r_drops;

endmodule

// File: tb/tb_prefetch_dma_arbiter.sv
// tb/tb_prefetch_dma_arbiter.sv - self-checking bench for prefetch_dma_arbiter
module tb_prefetch_dma_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        pf_enable_i;
  logic        demand_v_i;
  logic [31:0] demand_addr_i;
  logic        demand_ready_o;
  logic        demand_done_o;
  logic        pf_v_i;
  logic [31:0] pf_addr_i;
  logic        dma_pkt_v_o;
  logic [31:0] dma_pkt_addr_o;
  logic        dma_pkt_is_pf_o;
  logic        dma_pkt_ready_i;
  logic        dma_done_i;
  logic        pf_fill_done_o;
  logic [31:0] pf_fill_addr_o;
  logic [2:0]  pf_occupancy_o;
  logic [7:0]  pf_drop_count_o;

  prefetch_dma_arbiter dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .pf_enable_i     (pf_enable_i),
    .demand_v_i      (demand_v_i),
    .demand_addr_i   (demand_addr_i),
    .demand_ready_o  (demand_ready_o),
    .demand_done_o   (demand_done_o),
    .pf_v_i          (pf_v_i),
    .pf_addr_i       (pf_addr_i),
    .dma_pkt_v_o     (dma_pkt_v_o),
    .dma_pkt_addr_o  (dma_pkt_addr_o),
    .dma_pkt_is_pf_o (dma_pkt_is_pf_o),
    .dma_pkt_ready_i (dma_pkt_ready_i),
    .dma_done_i      (dma_done_i),
    .pf_fill_done_o  (pf_fill_done_o),
    .pf_fill_addr_o  (pf_fill_addr_o),
    .pf_occupancy_o  (pf_occupancy_o),
    .pf_drop_count_o (pf_drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: transaction phase, current block and a queue of (block, live) entries
  typedef struct packed {
    logic [25:0] blk;
    logic        live;
  } pf_ent_t;

  pf_ent_t     m_q[$];
  int          m_phase;   // 0 idle, 1 request presented, 2 awaiting completion
  logic [25:0] m_cur;
  bit          m_pf;
  int          m_drops;

  // ctl = {ready, v, is_pf&v, demand_done, pf_fill_done}
  logic [4:0]  exp_ctl, obs_ctl;
  logic [31:0] exp_addr, obs_addr, exp_fill, obs_fill;
  logic [2:0]  exp_occ, obs_occ;
  logic [7:0]  exp_drops, obs_drops;

  task automatic m_reset();
    m_q.delete();
    m_phase = 0;
    m_cur   = '0;
    m_pf    = 0;
    m_drops = 0;
  endtask

  task automatic m_update(input logic dv, input logic [31:0] da, input logic pv,
                          input logic [31:0] pa, input logic en, input logic rdy, input logic dn);
    logic [25:0] db, pb;
    bit acc, pop, drop, push;
    pf_ent_t ent;
    db   = da[31:6];
    pb   = pa[31:6];
    acc  = (m_phase == 0) && dv;
    pop  = (m_phase == 0) && !dv && en && (m_q.size() > 0);
    drop = 0;
    push = 0;
    if (en && pv) begin
      drop = (m_q.size() == 4) || (m_phase != 0 && pb == m_cur) || (acc && pb == db);
      foreach (m_q[i]) if (m_q[i].live && m_q[i].blk == pb) drop = 1;
      push = !drop;
    end
    if (drop && m_drops < 255) m_drops++;
    if (m_phase == 0) begin
      if (acc) begin
        m_cur = db; m_pf = 0; m_phase = 1;
      end else if (pop) begin
        ent = m_q.pop_front();
        if (ent.live) begin
          m_cur = ent.blk; m_pf = 1; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (rdy) m_phase = 2;
    end else if (dn) begin
      m_phase = 0;
    end
    if (acc) foreach (m_q[i]) if (m_q[i].blk == db) m_q[i].live = 0;
    if (push) m_q.push_back({pb, 1'b1});
    if (!en) m_q.delete();
  endtask

  // Drive one cycle of inputs, sample model expectations and DUT outputs before the edge
  task automatic step(input logic dv, input logic [31:0] da, input logic pv, input logic [31:0] pa,
                      input logic en, input logic rdy, input logic dn);
    bit fire;
    demand_v_i      = dv;
    demand_addr_i   = da;
    pf_v_i          = pv;
    pf_addr_i       = pa;
    pf_enable_i     = en;
    dma_pkt_ready_i = rdy;
    dma_done_i      = dn;
    #1;
    fire      = (m_phase == 2) && dn;
    exp_ctl   = {m_phase == 0, m_phase == 1, m_phase == 1 && m_pf, fire && !m_pf, fire && m_pf};
    exp_addr  = (m_phase == 1) ? {m_cur, 6'b0} : 32'h0;
    exp_fill  = (fire && m_pf) ? {m_cur, 6'b0} : 32'h0;
    exp_occ   = 3'(m_q.size());
    exp_drops = 8'(m_drops);
    obs_ctl   = {demand_ready_o, dma_pkt_v_o, dma_pkt_is_pf_o & dma_pkt_v_o, demand_done_o, pf_fill_done_o};
    obs_addr  = dma_pkt_v_o ? dma_pkt_addr_o : 32'h0;
    obs_fill  = pf_fill_done_o ? pf_fill_addr_o : 32'h0;
    obs_occ   = pf_occupancy_o;
    obs_drops = pf_drop_count_o;
    @(posedge clk_i);
    m_update(dv, da, pv, pa, en, rdy, dn);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    pf_enable_i = 1'b1; demand_v_i = 1'b0; demand_addr_i = '0; pf_v_i = 1'b0;
    pf_addr_i = '0; dma_pkt_ready_i = 1'b0; dma_done_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    pf_enable_i = 1'b1; demand_v_i = 1'b0; demand_addr_i = '0; pf_v_i = 1'b0;
    pf_addr_i = '0; dma_pkt_ready_i = 1'b0; dma_done_i = 1'b1;
    #3;
    n_total++;
    if ({demand_ready_o, dma_pkt_v_o, demand_done_o, pf_fill_done_o} !== 4'b1000) $display("FAIL reset_ctl got %b want 1000", {demand_ready_o, dma_pkt_v_o, demand_done_o, pf_fill_done_o});
    else n_pass++;
    n_total++;
    if ({dma_pkt_addr_o, pf_fill_addr_o, dma_pkt_is_pf_o, pf_occupancy_o, pf_drop_count_o} !== 76'h0) $display("FAIL reset_data got %h want 0", {dma_pkt_addr_o, pf_fill_addr_o, dma_pkt_is_pf_o, pf_occupancy_o, pf_drop_count_o});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_demand();
    do_reset();
    step(1, 32'h1000, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    n_total++;
    if (obs_ctl !== 5'b01000 || obs_addr !== 32'h1000) $display("FAIL demand_issue got ctl=%b addr=%h want 01000 1000", obs_ctl, obs_addr);
    else n_pass++;
    step(0, 0, 0, 0, 1, 0, 1);
    n_total++;
    if (obs_ctl !== 5'b00010) $display("FAIL demand_done got %b want 00010", obs_ctl);
    else n_pass++;
    step(0, 0, 0, 0, 1, 0, 1);
    n_total++;
    if (obs_ctl !== 5'b10000) $display("FAIL demand_after got %b want 10000", obs_ctl);
    else n_pass++;
  endtask

  task automatic test_pf_fifo();
    logic [31:0] pa [3] = '{32'h2040, 32'h2080, 32'h20C0};
    logic [32:0] issued[$];
    logic [31:0] fills[$];
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(0, 0, i < 3, (i < 3) ? pa[i] : 32'h0, 1, 1, 1);
      if (obs_ctl[3]) issued.push_back({obs_ctl[2], obs_addr});
      if (obs_ctl[0]) fills.push_back(obs_fill);
    end
    n_total++;
    if (issued.size() != 3 || fills.size() != 3) $display("FAIL pf_fifo_count got issued=%0d fills=%0d want 3 3", issued.size(), fills.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (issued[i] !== {1'b1, pa[i]} || fills[i] !== pa[i]) $display("FAIL pf_fifo_order[%0d] got %h/%h want %h", i, issued[i], fills[i], {1'b1, pa[i]});
        else n_pass++;
      end
    end
    n_total++;
    if (obs_occ !== 3'd0) $display("FAIL pf_fifo_occ got %0d want 0", obs_occ);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 32'h9000, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h2040 + 32'(i * 64), 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++;
    if (obs_occ !== 3'd4 || obs_drops !== 8'd1) $display("FAIL overflow got occ=%0d drops=%0d want 4 1", obs_occ, obs_drops);
    else n_pass++;
    step(0, 0, 1, 32'h2044, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++;
    if (obs_drops !== 8'd2) $display("FAIL dup_drop got %0d want 2", obs_drops);
    else n_pass++;
    // Keep hitting the in-flight block to drive the counter into saturation
    for (int i = 0; i < 300; i++) step(0, 0, 1, 32'h9000, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++;
    if (obs_drops !== 8'd255) $display("FAIL drop_saturate got %0d want 255", obs_drops);
    else n_pass++;
  endtask

  task automatic test_squash();
    logic [32:0] issued[$];
    logic [31:0] fills[$];
    int ddone = 0;
    do_reset();
    step(1, 32'h7000, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 32'h3000, 1, 0, 0);
    step(0, 0, 1, 32'h3040, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    n_total++;
    if (obs_occ !== 3'd2) $display("FAIL squash_setup got occ=%0d want 2", obs_occ);
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      step(i == 0, 32'h3048, 0, 0, 1, 1, 1);
      if (obs_ctl[3]) issued.push_back({obs_ctl[2], obs_addr});
      if (obs_ctl[0]) fills.push_back(obs_fill);
      if (obs_ctl[1]) ddone++;
    end
    n_total++;
    if (issued.size() != 2 || issued[0] !== {1'b0, 32'h3040} || issued[1] !== {1'b1, 32'h3000})
      $display("FAIL squash_order got n=%0d first=%h want 2 0_00003040 1_00003000", issued.size(), (issued.size() > 0) ? issued[0] : 33'h0);
    else n_pass++;
    n_total++;
    if (fills.size() != 1 || ddone != 1 || obs_occ !== 3'd0 || obs_drops !== 8'd0)
      $display("FAIL squash_end got fills=%0d ddone=%0d occ=%0d drops=%0d want 1 1 0 0", fills.size(), ddone, obs_occ, obs_drops);
    else n_pass++;
  endtask

  task automatic test_pf_disable();
    do_reset();
    step(0, 0, 1, 32'h6000, 1, 0, 0);
    step(0, 0, 1, 32'h6040, 1, 0, 0);
    step(0, 0, 1, 32'h6080, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (obs_occ !== 3'd2) $display("FAIL pf_dis_before got occ=%0d want 2", obs_occ);
    else n_pass++;
    step(0, 0, 1, 32'h6100, 0, 0, 0);
    n_total++;
    if (obs_occ !== 3'd0) $display("FAIL pf_dis_flush got occ=%0d want 0", obs_occ);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (obs_ctl !== 5'b00001 || obs_fill !== 32'h6000) $display("FAIL pf_dis_fill got ctl=%b addr=%h want 00001 6000", obs_ctl, obs_fill);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'h6140, 0, 1, 1);
      n_total++;
      if (obs_ctl[3] !== 1'b0 || obs_drops !== 8'd0) $display("FAIL pf_dis_idle[%0d] got v=%b drops=%0d want 0 0", i, obs_ctl[3], obs_drops);
      else n_pass++;
    end
  endtask

  task automatic test_reset_issue();
    do_reset();
    step(1, 32'hA000, 1, 32'hB000, 1, 0, 0);
    step(0, 0, 1, 32'hA000, 1, 0, 0);
    n_total++;
    if (dma_pkt_v_o !== 1'b1 || pf_drop_count_o !== 8'd1 || pf_occupancy_o !== 3'd1) $display("FAIL rst_pre got v=%b drops=%0d occ=%0d want 1 1 1", dma_pkt_v_o, pf_drop_count_o, pf_occupancy_o);
    else n_pass++;
    #2 reset_n_i = 1'b0;
    #1;
    n_total++;
    if (dma_pkt_v_o !== 1'b0 || demand_ready_o !== 1'b1) $display("FAIL rst_async got v=%b ready=%b want 0 1", dma_pkt_v_o, demand_ready_o);
    else n_pass++;
    do_reset();
    step(0, 0, 0, 0, 1, 1, 1);
    n_total++;
    if (obs_occ !== 3'd0 || obs_drops !== 8'd0 || obs_ctl !== 5'b10000) $display("FAIL rst_after got occ=%0d drops=%0d ctl=%b want 0 0 10000", obs_occ, obs_drops, obs_ctl);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        dv, pv, en, rdy, dn;
    logic [31:0] da, pa;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      dv  = ($urandom_range(0, 3) == 0);
      pv  = ($urandom_range(0, 1) == 0);
      en  = ($urandom_range(0, 15) != 0);
      rdy = ($urandom_range(0, 1) == 0);
      dn  = ($urandom_range(0, 2) == 0);
      da  = 32'h4000 + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 63));
      pa  = 32'h4000 + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 63));
      step(dv, da, pv, pa, en, rdy, dn);
      n_total++;
      if (obs_ctl !== exp_ctl) $display("FAIL rnd_ctl c=%0d got %b want %b", c, obs_ctl, exp_ctl);
      else n_pass++;
      n_total++;
      if (obs_addr !== exp_addr) $display("FAIL rnd_addr c=%0d got %h want %h", c, obs_addr, exp_addr);
      else n_pass++;
      n_total++;
      if (obs_fill !== exp_fill) $display("FAIL rnd_fill c=%0d got %h want %h", c, obs_fill, exp_fill);
      else n_pass++;
      n_total++;
      if (obs_occ !== exp_occ) $display("FAIL rnd_occ c=%0d got %0d want %0d", c, obs_occ, exp_occ);
      else n_pass++;
      n_total++;
      if (obs_drops !== exp_drops) $display("FAIL rnd_drops c=%0d got %0d want %0d", c, obs_drops, exp_drops);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_demand();
    test_pf_fifo();
    test_overflow();
    test_squash();
    test_pf_disable();
    test_reset_issue();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prefetch_dma_arbiter.md
Name: prefetch_dma_arbiter

Overview:
Sequences and shares the single cache DMA request port between demand misses and stream-prefetch requests.
- Demand misses have strict priority over prefetches.
- Prefetch addresses from the stream prefetcher are buffered in a small queue, deduplicated at cache-block granularity, and squashed when a demand miss to the same block arrives.
- One DMA transaction is in flight at a time. Completions are routed back to either the demand path or the prefetch-fill path.

Parameters:
addr_width_p, 32, byte address width
block_offset_width_p, 6, low address bits ignored for block matching (64 B blocks)
pf_queue_els_p, 4, prefetch queue depth (power of 2, >=2)
drop_count_width_p, 8, width of saturating drop counter

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
pf_enable_i  in  1  prefetch enable; low flushes queue and blocks prefetch issue
demand_v_i  in  1  demand miss request valid
demand_addr_i  in  addr_width_p  demand miss address
demand_ready_o  out  1  demand accepted when demand_v_i & demand_ready_o
demand_done_o  out  1  one-cycle pulse: demand DMA completed
pf_v_i  in  1  prefetch push (no backpressure; may be dropped)
pf_addr_i  in  addr_width_p  prefetch address
dma_pkt_v_o  out  1  DMA request valid
dma_pkt_addr_o  out  addr_width_p  DMA request address, block-aligned (offset bits zero)
dma_pkt_is_pf_o  out  1  current DMA request is a prefetch
dma_pkt_ready_i  in  1  DMA accepts request when v & ready
dma_done_i  in  1  in-flight DMA transaction complete
pf_fill_done_o  out  1  one-cycle pulse: prefetch fill completed
pf_fill_addr_o  out  addr_width_p  block address of completed prefetch, valid with pulse
pf_occupancy_o  out  $clog2(pf_queue_els_p)+1  queue slots in use
pf_drop_count_o  out  drop_count_width_p  saturating count of dropped prefetches

Behaviour:
Reset:
- When reset_n_i is low, all state clears immediately: FSM=IDLE, queue empty, counters 0.
- All outputs read 0, except demand_ready_o, which reads 1.
- Reset mid-transaction abandons the transaction. No done pulse is generated for it.

FSM states: IDLE, ISSUE, WAIT.
- IDLE: demand_ready_o=1.
  - If demand_v_i: latch block address, src=demand, go to ISSUE.
  - Else if pf_enable_i and head slot occupied:
    - head valid: pop, latch, src=pf, go to ISSUE.
    - head squashed: pop and discard, stay in IDLE (one cycle per squashed entry).
  - Else stay in IDLE.
- ISSUE: dma_pkt_v_o=1; addr and is_pf held stable. Go to WAIT on dma_pkt_ready_i.
- WAIT: on dma_done_i, go to IDLE. In that same cycle (combinational) pulse demand_done_o or pf_fill_done_o according to src; pf_fill_addr_o = latched address.
- demand_ready_o=0 in ISSUE and WAIT.
- Minimum demand latency: accept in cycle N, dma_pkt_v_o in N+1.

Queue:
- Circular FIFO with per-slot valid bits; head/tail pointers wrap modulo pf_queue_els_p.
- Occupancy counts occupied slots, including squashed slots not yet popped.
- Push: pf_v_i & pf_enable_i. All checks use start-of-cycle state. Drop and increment pf_drop_count_o (saturating at all-ones) if any of:
  - queue is full, even if a pop occurs in the same cycle;
  - the block matches any valid queue entry;
  - the block matches the in-flight or issuing block (state ISSUE/WAIT).
  Otherwise write the block address at tail with valid=1.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- Squash: when a demand is accepted, every valid queue entry with the same block is marked invalid the next cycle. Squashes are not counted as drops. An in-flight prefetch to that block is not cancelled.
- A same-cycle push whose block equals the accepted demand block is dropped and counted.
- pf_enable_i low: queue flushed next cycle (occupancy 0); pushes ignored and not counted.
  - An in-flight prefetch completes normally with pf_fill_done_o.
  - The drop counter is not cleared.
- Block compare uses bits [addr_width_p-1:block_offset_width_p].

Test Plan:
- Reset, pf_enable_i=1, demand 0x1000 -> dma_pkt_v_o next cycle, addr 0x1000, is_pf=0; ready, then dma_done_i -> demand_done_o one pulse; pf_fill_done_o stays 0.
- Push pf 0x2040, 0x2080, 0x20C0 with no demand -> issued in FIFO order, each with is_pf=1; each completion pulses pf_fill_done_o with its address; occupancy ends at 0.
- Hold DMA busy (WAIT), push 5 distinct blocks with depth 4 -> occupancy 4, drop count 1. Push 0x2044 while 0x2040 is queued -> drop count 2.
- Queue holds 0x3000, 0x3040; demand 0x3048 accepted -> demand issued first; 0x3040 squashed and popped in one IDLE cycle without issue; 0x3000 issued; drop count unchanged.
- Demand and queued prefetch pending together in IDLE -> demand wins. Deassert pf_enable_i during a prefetch WAIT -> queue empty next cycle, in-flight fill still pulses pf_fill_done_o, no further prefetch issues.
- Assert reset_n_i low during ISSUE -> dma_pkt_v_o drops to 0 asynchronously; after release, occupancy and drop count read 0.
